// File: rtl/video_timing_gen_if.sv
// Video timing output bundle: raster position, sync/enable and test-pattern pixel data.
// The generator drives the master side; sinks (encoder, pattern checker) use the slave side.
interface video_timing_gen_if;
    logic [9:0] CX;
    logic [9:0] CY;
    logic       VDE;
    logic [1:0] CD;
    logic       frame_start;
    logic       line_end;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    modport master (output CX, CY, VDE, CD, frame_start, line_end, red, green, blue);
    modport slave  (input  CX, CY, VDE, CD, frame_start, line_end, red, green, blue);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with registered, zero-skew position/sync/enable outputs.
// Optional colour-bar test pattern is built only when TEST_PATTERN_EN is defined.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               pixclk,
    input  logic               rst,
    video_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       running;
    logic [9:0] cx_q, cy_q;
    logic [9:0] nx, ny;
    logic       vde_n, hs_act, vs_act;
    logic       vde_q, fs_q, le_q;
    logic [1:0] cd_q;
    logic [23:0] rgb_q;

    // All decodes are taken from the next position so they land in the same
    // register stage as CX/CY; the first cycle out of reset presents 0,0.
    always_comb begin
        nx = '0;
        ny = '0;
        if (running) begin
            if (cx_q == H_LAST) begin
                nx = '0;
                ny = (cy_q == V_LAST) ? 10'd0 : cy_q + 10'd1;
            end else begin
                nx = cx_q + 10'd1;
                ny = cy_q;
            end
        end
    end

    assign vde_n  = (nx < H_ACT) && (ny < V_ACT);
    assign hs_act = (nx >= HS_BEGIN) && (nx < HS_END);
    assign vs_act = (ny >= VS_BEGIN) && (ny < VS_END);

    always_ff @(posedge pixclk) begin
        if (rst) begin
            running <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            vde_q   <= 1'b0;
            cd_q    <= {~SYNC_POL, ~SYNC_POL};
            fs_q    <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            running <= 1'b1;
            cx_q    <= nx;
            cy_q    <= ny;
            vde_q   <= vde_n;
            cd_q    <= {(vs_act ? SYNC_POL : ~SYNC_POL), (hs_act ? SYNC_POL : ~SYNC_POL)};
            fs_q    <= (nx == 10'd0) && (ny == 10'd0);
            le_q    <= (nx == H_LAST);
        end
    end

`ifdef TEST_PATTERN_EN
    logic [2:0] bar;

    // Bars are 80 pixels wide; anything past the eighth bar decodes as black.
    always_comb begin
        if      (nx < 10'd80)  bar = 3'd0;
        else if (nx < 10'd160) bar = 3'd1;
        else if (nx < 10'd240) bar = 3'd2;
        else if (nx < 10'd320) bar = 3'd3;
        else if (nx < 10'd400) bar = 3'd4;
        else if (nx < 10'd480) bar = 3'd5;
        else if (nx < 10'd560) bar = 3'd6;
        else                   bar = 3'd7;
    end

    always_ff @(posedge pixclk) begin
        if (rst || !vde_n) rgb_q <= '0;
        else               rgb_q <= {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    end
`else
    assign rgb_q = '0;
`endif

    assign vid.CX          = cx_q;
    assign vid.CY          = cy_q;
    assign vid.VDE         = vde_q;
    assign vid.CD          = cd_q;
    assign vid.frame_start = fs_q;
    assign vid.line_end    = le_q;
    assign vid.red         = rgb_q[23:16];
    assign vid.green       = rgb_q[15:8];
    assign vid.blue        = rgb_q[7:0];
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default horizontal timing, shortened 18-line frame.
// Expected samples are queued by tick number; the monitor compares each as its tick arrives.
module tb_video_timing_gen;
  localparam int unsigned H_TOT = 800;
  localparam int unsigned V_TOT = 18;
  localparam int unsigned F     = H_TOT * V_TOT;
  localparam int unsigned T0    = 6;
  localparam int unsigned NR    = F + 10 * H_TOT + 300;
  localparam int unsigned T1    = T0 + NR + 2;

  typedef struct {
    int unsigned t;
    string       nm;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic        vde;
    logic [1:0]  cd;
    logic        fs;
    logic        le;
    logic [23:0] rgb;
  } exp_t;

  logic pixclk;
  logic rst;
  int unsigned tick;
  int total;
  int bad;
  int fs_cnt;
  int le_cnt;
  exp_t exp_q[$];
  exp_t e;

  video_timing_gen_if vif();

  video_timing_gen #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .pixclk(pixclk),
    .rst(rst),
    .vid(vif)
  );

  // clock / reset
  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  initial tick = 0;
  always @(posedge pixclk) tick <= tick + 1;

  function automatic logic [23:0] pat(input logic [23:0] c);
`ifdef TEST_PATTERN_EN
    return c;
`else
    return 24'h0 & c;
`endif
  endfunction

  task automatic push(input int unsigned t, input string nm, input int cx, input int cy,
                      input logic vde, input logic [1:0] cd, input logic fs, input logic le,
                      input logic [23:0] rgb);
    exp_t x;
    x.t = t; x.nm = nm; x.cx = 10'(cx); x.cy = 10'(cy);
    x.vde = vde; x.cd = cd; x.fs = fs; x.le = le; x.rgb = rgb;
    exp_q.push_back(x);
  endtask

  // monitor / scoreboard
  initial begin
    total = 0; bad = 0; fs_cnt = 0; le_cnt = 0;
  end

  always @(negedge pixclk) begin
    if (exp_q.size() > 0 && exp_q[0].t == tick) begin
      e = exp_q.pop_front();
      total++;
      if (vif.CX !== e.cx || vif.CY !== e.cy || vif.VDE !== e.vde || vif.CD !== e.cd ||
          vif.frame_start !== e.fs || vif.line_end !== e.le ||
          {vif.red, vif.green, vif.blue} !== e.rgb) begin
        bad++;
        $display("FAIL %s: got cx=%0d cy=%0d vde=%b cd=%b fs=%b le=%b rgb=%h, want cx=%0d cy=%0d vde=%b cd=%b fs=%b le=%b rgb=%h",
                 e.nm, vif.CX, vif.CY, vif.VDE, vif.CD, vif.frame_start, vif.line_end,
                 {vif.red, vif.green, vif.blue}, e.cx, e.cy, e.vde, e.cd, e.fs, e.le, e.rgb);
      end
    end
    if (tick >= T0 && tick < T0 + F) begin
      fs_cnt += int'(vif.frame_start);
      le_cnt += int'(vif.line_end);
    end
    if (tick == T0 + F) begin
      total++;
      if (fs_cnt != 1) begin
        bad++;
        $display("FAIL frame_pulses: got %0d, want 1", fs_cnt);
      end
      total++;
      if (le_cnt != int'(V_TOT)) begin
        bad++;
        $display("FAIL line_pulses: got %0d, want %0d", le_cnt, V_TOT);
      end
    end
  end

  // driver
  initial begin
    rst = 1'b1;
    push(2,            "rst_hold",   0,   0,  0, 2'b11, 0, 0, 24'h0);
    push(5,            "rst_last",   0,   0,  0, 2'b11, 0, 0, 24'h0);
    push(T0,           "first",      0,   0,  1, 2'b11, 1, 0, pat(24'hFFFFFF));
    push(T0 + 639,     "h_act_end",  639, 0,  1, 2'b11, 0, 0, pat(24'h000000));
    push(T0 + 640,     "h_blank",    640, 0,  0, 2'b11, 0, 0, 24'h0);
    push(T0 + 655,     "hs_pre",     655, 0,  0, 2'b11, 0, 0, 24'h0);
    push(T0 + 656,     "hs_begin",   656, 0,  0, 2'b10, 0, 0, 24'h0);
    push(T0 + 751,     "hs_last",    751, 0,  0, 2'b10, 0, 0, 24'h0);
    push(T0 + 752,     "hs_after",   752, 0,  0, 2'b11, 0, 0, 24'h0);
    push(T0 + 799,     "line_end",   799, 0,  0, 2'b11, 0, 1, 24'h0);
    push(T0 + 800,     "line1",      0,   1,  1, 2'b11, 0, 0, pat(24'hFFFFFF));
    push(T0 + 8085,    "pat_yellow", 85,  10, 1, 2'b11, 0, 0, pat(24'hFFFF00));
    push(T0 + 8400,    "pat_red",    400, 10, 1, 2'b11, 0, 0, pat(24'hFF0000));
    push(T0 + 8639,    "pat_black",  639, 10, 1, 2'b11, 0, 0, pat(24'h000000));
    push(T0 + 8700,    "pat_blank",  700, 10, 0, 2'b10, 0, 0, 24'h0);
    push(T0 + 8900,    "v_act_last", 100, 11, 1, 2'b11, 0, 0, pat(24'hFFFF00));
    push(T0 + 9700,    "v_blank",    100, 12, 0, 2'b11, 0, 0, 24'h0);
    push(T0 + 10400,   "vs_pre",     0,   13, 0, 2'b11, 0, 0, 24'h0);
    push(T0 + 11200,   "vs_begin",   0,   14, 0, 2'b01, 0, 0, 24'h0);
    push(T0 + 11900,   "vs_hs",      700, 14, 0, 2'b00, 0, 0, 24'h0);
    push(T0 + 12799,   "vs_last",    799, 15, 0, 2'b01, 0, 1, 24'h0);
    push(T0 + 12800,   "vs_after",   0,   16, 0, 2'b11, 0, 0, 24'h0);
    push(T0 + F - 1,   "frame_last", 799, 17, 0, 2'b11, 0, 1, 24'h0);
    push(T0 + F,       "frame_wrap", 0,   0,  1, 2'b11, 1, 0, pat(24'hFFFFFF));
    push(T0 + NR,      "pre_reset",  300, 10, 1, 2'b11, 0, 0, pat(24'h00FF00));
    push(T0 + NR + 1,  "mid_reset",  0,   0,  0, 2'b11, 0, 0, 24'h0);
    push(T1,           "restart",    0,   0,  1, 2'b11, 1, 0, pat(24'hFFFFFF));
    push(T1 + 1,       "restart_x1", 1,   0,  1, 2'b11, 0, 0, pat(24'hFFFFFF));
    push(T1 + 800,     "restart_y1", 0,   1,  1, 2'b11, 0, 0, pat(24'hFFFFFF));

    repeat (5) @(posedge pixclk);
    @(negedge pixclk);
    rst = 1'b0;
    while (tick != T0 + NR) @(negedge pixclk);
    rst = 1'b1;
    @(negedge pixclk);
    rst = 1'b0;
    while (tick < T1 + 810) @(negedge pixclk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch / sync width / back porch in pixels; H_TOTAL = 800.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch / sync / back porch in lines; V_TOTAL = 525.
REQ-005 Parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-006 pixclk  input  1  pixel clock; single clock domain; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 CX  output  10  current horizontal position, 0..H_TOTAL-1.
REQ-009 CY  output  10  current vertical position, 0..V_TOTAL-1.
REQ-010 VDE  output  1  video data enable, feeds TMDS encoder VDE.
REQ-011 CD  output  2  {vsync, hsync}, feeds encoder CD on the blue channel.
REQ-012 frame_start  output  1  one-cycle pulse at CX=0, CY=0.
REQ-013 line_end  output  1  one-cycle pulse at CX=H_TOTAL-1.
REQ-014 red, green, blue  output  8 each  test-pattern pixel data (see Configuration).

Function
REQ-015 All outputs SHALL be registered; VDE, CD, frame_start, line_end and pattern SHALL correspond to the CX/CY value presented in the same cycle (zero relative skew).
REQ-016 CX SHALL increment by 1 per pixclk and wrap from H_TOTAL-1 to 0.
REQ-017 CY SHALL increment by 1 only in the cycle CX wraps, and wrap from V_TOTAL-1 to 0 when CX and CY wrap simultaneously.
REQ-018 VDE SHALL be 1 iff CX < H_ACTIVE and CY < V_ACTIVE.
REQ-019 hsync SHALL be at active level iff H_ACTIVE+H_FP <= CX < H_ACTIVE+H_FP+H_SYNC (default 656..751), else inactive.
REQ-020 vsync SHALL be at active level iff V_ACTIVE+V_FP <= CY < V_ACTIVE+V_FP+V_SYNC (default 490..491), independent of CX.
REQ-021 Active level = SYNC_POL; inactive level = ~SYNC_POL.
REQ-022 Frame period SHALL be exactly H_TOTAL*V_TOTAL cycles (420000 default); no dropped or duplicated lines.
REQ-023 Counter widths SHALL be 10 bits; parameter totals above 1024 are unsupported.

Reset
REQ-024 While rst=1: CX=0, CY=0, VDE=0, CD={~SYNC_POL,~SYNC_POL}, frame_start=0, line_end=0, red/green/blue=0.
REQ-025 First cycle after rst deasserts: CX=0, CY=0, VDE=1, frame_start=1; counting proceeds per REQ-016/017.
REQ-026 rst asserted mid-frame SHALL abandon the frame immediately; no partial-line completion.

Configuration
REQ-027 Macro TEST_PATTERN_EN defined: red/green/blue SHALL output eight 80-pixel colour bars across CX 0..639: white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF or 8'h00); all three 0 when VDE=0.
REQ-028 Macro TEST_PATTERN_EN undefined: red/green/blue SHALL be constant 0 and no bar-decode logic SHALL be synthesized; timing behaviour unchanged.

Verification
REQ-029 Reset 5 cycles, release -> frame_start=1 at CX=0,CY=0; next frame_start exactly 420000 cycles later; no other pulses in between.
REQ-030 Run one line from CX=0 -> VDE=1 for CX 0..639, 0 for 640..799; CD[0]=0 for CX 656..751 only; line_end=1 at CX=799; CY 0->1 on following cycle.
REQ-031 Run to CY=489..492 -> CD[1]=0 for every cycle of lines 490 and 491 only; VDE=0 for all of CY 480..524.
REQ-032 Wrap at CX=799,CY=524 -> next cycle CX=0, CY=0, frame_start=1, VDE=1.
REQ-033 Assert rst for 1 cycle at CX=300,CY=200 -> during reset VDE=0, CD=2'b11; next cycle CX=0,CY=0,frame_start=1.
REQ-034 With TEST_PATTERN_EN, CY=10: CX=85 -> {FF,FF,00}; CX=400 -> {FF,00,00}; CX=639 -> {00,00,00}; CX=700 -> {00,00,00}; without macro all zero.
